// File: rtl/proc_ctx_pkg.sv
// Shared types and helpers for the process context switcher.
package proc_ctx_pkg;

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StSave} ctx_state_e;

    localparam int unsigned DefaultPcW = 10;

    function automatic int unsigned slot_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/proc_quantum_timer.sv
// Counts enabled RUN cycles and flags the cycle on which the time slice runs out.
module proc_quantum_timer #(
    parameter int unsigned QUANTUM = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int unsigned CntW = (QUANTUM > 2) ? $clog2(QUANTUM) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(QUANTUM - 1);

    logic [CntW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            count_q <= '0;
        end else if (enable_i) begin
            count_q <= count_q + CntW'(1);
        end
    end

    // Expiry is combinational so preempt lands in the last RUN cycle itself.
    assign expire_o = enable_i && (count_q == LastCnt);

endmodule

// File: rtl/proc_ctx_switcher.sv
// Context-switch controller: per-slot saved PCs, start/yield handling, and optional
// quantum preemption when QUANTUM_PREEMPT_EN is defined.
module proc_ctx_switcher
    import proc_ctx_pkg::*;
#(
    parameter int unsigned NUM_PROCS = 4,
    parameter int unsigned PC_W      = DefaultPcW,
    parameter int unsigned QUANTUM   = 64,
    localparam int unsigned SlotW    = slot_w(NUM_PROCS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hlt_i,
    input  logic             start_req_i,
    input  logic [SlotW-1:0] start_slot_i,
    input  logic             yield_req_i,
    input  logic             wr_en_i,
    input  logic [SlotW-1:0] wr_slot_i,
    input  logic [PC_W-1:0]  wr_pc_i,
    input  logic [PC_W-1:0]  only_proc_pc_i,
    output logic             proc_num_o,
    output logic [PC_W-1:0]  stored_pc_o,
    output logic             change_proc_pc_o,
    output logic [SlotW-1:0] cur_slot_o,
    output logic             preempt_o,
    output logic             busy_o
);

    ctx_state_e       state_q;
    logic [PC_W-1:0]  ctx_pc_q [NUM_PROCS];
    logic [SlotW-1:0] cur_slot_q;
    logic [PC_W-1:0]  stored_pc_q;
    logic             proc_num_q;
    logic             change_q;
    logic             busy_q;
    logic             run_exit;

`ifdef QUANTUM_PREEMPT_EN
    logic expire;

    proc_quantum_timer #(
        .QUANTUM (QUANTUM)
    ) u_quantum_timer (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (state_q == StLoad),
        .enable_i ((state_q == StRun) && !hlt_i),
        .expire_o (expire)
    );

    // A yield in the expiry cycle wins and suppresses the preempt pulse.
    assign preempt_o = expire && !yield_req_i;
    assign run_exit  = yield_req_i || expire;
`else
    logic unused_hlt;
    assign unused_hlt = hlt_i;
    assign preempt_o  = 1'b0;
    assign run_exit   = yield_req_i;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cur_slot_q  <= '0;
            stored_pc_q <= '0;
            proc_num_q  <= 1'b0;
            change_q    <= 1'b0;
            busy_q      <= 1'b0;
            for (int i = 0; i < NUM_PROCS; i++) begin
                ctx_pc_q[i] <= '0;
            end
        end else begin
            change_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (wr_en_i) begin
                        ctx_pc_q[wr_slot_i] <= wr_pc_i;
                    end
                    if (start_req_i) begin
                        cur_slot_q  <= start_slot_i;
                        // Same-cycle write to the started slot is forwarded into LOAD.
                        stored_pc_q <= (wr_en_i && (wr_slot_i == start_slot_i)) ?
                                       wr_pc_i : ctx_pc_q[start_slot_i];
                        change_q    <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= StLoad;
                    end
                end
                StLoad: begin
                    proc_num_q <= 1'b1;
                    state_q    <= StRun;
                end
                StRun: begin
                    if (run_exit) begin
                        proc_num_q <= 1'b0;
                        state_q    <= StSave;
                    end
                end
                StSave: begin
                    ctx_pc_q[cur_slot_q] <= only_proc_pc_i;
                    busy_q               <= 1'b0;
                    state_q              <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign proc_num_o       = proc_num_q;
    assign stored_pc_o      = stored_pc_q;
    assign change_proc_pc_o = change_q;
    assign cur_slot_o       = cur_slot_q;
    assign busy_o           = busy_q;

endmodule

// File: tb/tb_proc_ctx_switcher.sv
// Directed plus randomized bench for proc_ctx_switcher; follows QUANTUM_PREEMPT_EN like the RTL.
module tb_proc_ctx_switcher;

    localparam int unsigned NumProcs = 4;
    localparam int unsigned PcW      = 10;
    localparam int unsigned Quantum  = 8;
    localparam int unsigned SlotW    = 2;
`ifdef QUANTUM_PREEMPT_EN
    localparam bit PreemptEn = 1'b1;
`else
    localparam bit PreemptEn = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             hlt = 1'b0;
    logic             start_req = 1'b0;
    logic [SlotW-1:0] start_slot = '0;
    logic             yield_req = 1'b0;
    logic             wr_en = 1'b0;
    logic [SlotW-1:0] wr_slot = '0;
    logic [PcW-1:0]   wr_pc = '0;
    logic [PcW-1:0]   only_proc_pc = '0;
    logic             proc_num;
    logic [PcW-1:0]   stored_pc;
    logic             change_proc_pc;
    logic [SlotW-1:0] cur_slot;
    logic             preempt;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: saved PC per slot, plus the slot and value of the last load.
    logic [PcW-1:0] model_tbl [NumProcs];
    int             cur = 0;
    logic [PcW-1:0] last_load = '0;

    proc_ctx_switcher #(
        .NUM_PROCS (NumProcs),
        .PC_W      (PcW),
        .QUANTUM   (Quantum)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .hlt_i            (hlt),
        .start_req_i      (start_req),
        .start_slot_i     (start_slot),
        .yield_req_i      (yield_req),
        .wr_en_i          (wr_en),
        .wr_slot_i        (wr_slot),
        .wr_pc_i          (wr_pc),
        .only_proc_pc_i   (only_proc_pc),
        .proc_num_o       (proc_num),
        .stored_pc_o      (stored_pc),
        .change_proc_pc_o (change_proc_pc),
        .cur_slot_o       (cur_slot),
        .preempt_o        (preempt),
        .busy_o           (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_slot(input int slot, input logic [PcW-1:0] pc);
        wr_en   = 1'b1;
        wr_slot = SlotW'(slot);
        wr_pc   = pc;
        step();
        wr_en = 1'b0;
        model_tbl[slot] = pc;
    endtask

    task automatic start(input int slot, input bit with_wr, input logic [PcW-1:0] pc);
        start_req  = 1'b1;
        start_slot = SlotW'(slot);
        if (with_wr) begin
            wr_en   = 1'b1;
            wr_slot = SlotW'(slot);
            wr_pc   = pc;
            model_tbl[slot] = pc;
        end
        step();
        start_req = 1'b0;
        wr_en     = 1'b0;
        cur       = slot;
        last_load = model_tbl[slot];
        chk("load change_proc_pc", 32'(change_proc_pc), 1);
        chk("load proc_num", 32'(proc_num), 0);
        chk("load stored_pc", 32'(stored_pc), 32'(last_load));
        chk("load cur_slot", 32'(cur_slot), 32'(slot));
        chk("load busy", 32'(busy), 1);
        step();
        chk("run entry proc_num", 32'(proc_num), 1);
        chk("run entry change_proc_pc", 32'(change_proc_pc), 0);
    endtask

    // One RUN phase: per-cycle hlt from hlt_mask, yield at yield_cyc, optional ignored
    // write/start at poke_cyc, then SAVE with resume_pc on the PC input.
    task automatic run_context(input logic [63:0] hlt_mask, input int yield_cyc,
                               input int poke_cyc, input logic [PcW-1:0] resume_pc,
                               output int exit_cyc);
        int cnt = 0;
        bit done = 1'b0;
        bit expire;
        exit_cyc = -1;
        for (int c = 0; c <= yield_cyc && !done; c++) begin
            hlt          = (c < 64) ? hlt_mask[c] : 1'b0;
            yield_req    = (c == yield_cyc);
            only_proc_pc = PcW'($urandom);
            if (c == poke_cyc) begin
                wr_en      = 1'b1;
                wr_slot    = SlotW'($urandom);
                wr_pc      = PcW'($urandom);
                start_req  = 1'b1;
                start_slot = SlotW'($urandom);
            end
            #1;
            expire = PreemptEn && !hlt && (cnt == Quantum - 1);
            chk("run proc_num", 32'(proc_num), 1);
            chk("run preempt", 32'(preempt), 32'(expire && !yield_req));
            chk("run stored_pc hold", 32'(stored_pc), 32'(last_load));
            if (yield_req || expire) begin
                done     = 1'b1;
                exit_cyc = c;
            end
            if (!hlt) cnt++;
            step();
            yield_req = 1'b0;
            hlt       = 1'b0;
            wr_en     = 1'b0;
            start_req = 1'b0;
        end
        only_proc_pc = resume_pc;
        #1;
        chk("save proc_num", 32'(proc_num), 0);
        chk("save busy", 32'(busy), 1);
        chk("save preempt", 32'(preempt), 0);
        step();
        model_tbl[cur] = resume_pc;
        chk("idle busy", 32'(busy), 0);
        chk("idle cur_slot", 32'(cur_slot), 32'(cur));
    endtask

    initial begin
        int ex;
        logic [63:0] mask;
        int slot;
        for (int i = 0; i < NumProcs; i++) model_tbl[i] = '0;

        step();
        step();
        reset = 1'b0;
        chk("reset proc_num", 32'(proc_num), 0);
        chk("reset change_proc_pc", 32'(change_proc_pc), 0);
        chk("reset stored_pc", 32'(stored_pc), 0);
        chk("reset preempt", 32'(preempt), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset cur_slot", 32'(cur_slot), 0);

        // Basic load, yield and resume of slot 1.
        write_slot(1, 10'h120);
        start(1, 1'b0, '0);
        run_context(64'h0, 3, -1, 10'h12A, ex);
        chk("yield exit cycle", 32'(ex), 3);
        start(1, 1'b0, '0);
        chk("resume pc", 32'(stored_pc), 32'h12A);

        // Quantum expiry with no halts.
        run_context(64'h0, 30, -1, 10'h200, ex);
        chk("quantum exit cycle", 32'(ex), PreemptEn ? 32'd7 : 32'd30);

        // Three halted RUN cycles push expiry out by three.
        start(1, 1'b0, '0);
        run_context(64'hE, 40, -1, 10'h201, ex);
        chk("halted quantum exit cycle", 32'(ex), PreemptEn ? 32'd10 : 32'd40);

        // Yield coincides with expiry.
        start(2, 1'b0, '0);
        run_context(64'h0, 7, -1, 10'h2B0, ex);
        chk("yield+expiry exit cycle", 32'(ex), 7);

        // Writes and start requests during RUN are ignored.
        start(0, 1'b0, '0);
        run_context(64'h0, 5, 2, 10'h0C4, ex);
        start(3, 1'b0, '0);
        chk("table untouched by run write", 32'(stored_pc), 0);
        run_context(64'h0, 0, -1, 10'h033, ex);
        start(2, 1'b0, '0);
        chk("slot2 after poke", 32'(stored_pc), 32'h2B0);
        run_context(64'h0, 1, -1, 10'h2B1, ex);

        // Write and start to the same slot in one cycle.
        start(2, 1'b1, 10'h0AB);
        run_context(64'h0, 2, -1, 10'h0AC, ex);

        // Randomized contexts.
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                write_slot(int'($urandom_range(0, NumProcs - 1)), PcW'($urandom));
            end
            slot = int'($urandom_range(0, NumProcs - 1));
            mask = {$urandom, $urandom} & {$urandom, $urandom};
            start(slot, $urandom_range(0, 3) == 0, PcW'($urandom));
            run_context(mask, int'($urandom_range(0, 20)),
                        ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : -1,
                        PcW'($urandom), ex);
        end

        // Reset in the middle of RUN discards the context and clears the table.
        for (int i = 0; i < NumProcs; i++) write_slot(i, PcW'(10'h100 + i * 3));
        start(1, 1'b0, '0);
        only_proc_pc = 10'h3C3;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst-run proc_num", 32'(proc_num), 0);
        chk("rst-run busy", 32'(busy), 0);
        chk("rst-run stored_pc", 32'(stored_pc), 0);
        chk("rst-run cur_slot", 32'(cur_slot), 0);
        for (int i = 0; i < NumProcs; i++) model_tbl[i] = '0;
        start(1, 1'b0, '0);
        chk("rst-run slot1 cleared", 32'(stored_pc), 0);
        run_context(64'h0, 1, -1, 10'h011, ex);
        start(3, 1'b0, '0);
        chk("rst-run slot3 cleared", 32'(stored_pc), 0);
        run_context(64'h0, 0, -1, 10'h013, ex);
        start(1, 1'b0, '0);
        chk("post-reset save", 32'(stored_pc), 32'h011);
        run_context(64'h0, 0, -1, 10'h012, ex);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/proc_ctx_switcher.md
Name: proc_ctx_switcher

Overview:
- Context-switch controller that drives the process-select and PC-restore inputs of the program counter (`proc_num`, `stored_pc`, `change_proc_pc`).
- Consumes the counter's process-PC view (`only_proc_pc`) and holds one saved PC per process slot.
- Handles OS-requested process start, voluntary yield, and quantum-based preemption.
- Sits between the control unit (OS syscall decode) and the PC register.

Parameters:
- NUM_PROCS, 4, number of process context slots (power of 2, ≥2).
- PC_W, 10, program counter width.
- QUANTUM, 64, process-mode non-halted cycles before preemption (≥2).

Ports:
- clk  in  1  clock.
- reset  in  1  reset; synchronous, active-high.
- hlt  in  1  core halted; freezes quantum counting.
- start_req  in  1  OS requests run of process start_slot.
- start_slot  in  log2(NUM_PROCS)  slot to run.
- yield_req  in  1  running process returns control to OS.
- wr_en  in  1  OS writes initial PC into table.
- wr_slot  in  log2(NUM_PROCS)  write slot.
- wr_pc  in  PC_W  write data.
- only_proc_pc  in  PC_W  current process PC from PC register.
- proc_num  out  1  0 = OS PC active, 1 = process PC active.
- stored_pc  out  PC_W  PC to load into process PC.
- change_proc_pc  out  1  load strobe, asserted only while proc_num=0.
- cur_slot  out  log2(NUM_PROCS)  slot currently or last run.
- preempt  out  1  one-cycle pulse when quantum expired.
- busy  out  1  state != IDLE.

Behaviour:
- FSM states: IDLE, LOAD, RUN, SAVE. All transitions on posedge clk.
- Reset: state=IDLE, all table entries=0, cur_slot=0, quantum count=0. Outputs proc_num=0, change_proc_pc=0, stored_pc=0, preempt=0, busy=0. Reset mid-RUN aborts without saving.
- IDLE:
  - wr_en: table[wr_slot] <= wr_pc.
  - start_req: cur_slot <= start_slot, go to LOAD.
  - wr_en and start_req in the same cycle to the same slot: the write lands first; LOAD presents the new value.
- LOAD (1 cycle):
  - proc_num=0, change_proc_pc=1, stored_pc=table[cur_slot].
  - Quantum count cleared. Next state RUN.
- RUN:
  - proc_num=1, change_proc_pc=0.
  - Count increments on cycles with hlt=0.
  - yield_req=1 goes to SAVE (preempt stays 0).
  - Otherwise, if count==QUANTUM-1 and hlt=0, assert preempt for this cycle and go to SAVE.
  - yield and expiry in the same cycle: single SAVE, preempt=0.
- SAVE (1 cycle):
  - proc_num=0.
  - table[cur_slot] <= only_proc_pc. This is the post-edge PC, i.e. the resume address.
  - Next state IDLE.
- Latency: start_req to proc_num=1 is 2 cycles. Yield to proc_num=0 is 1 cycle.
- Ignored inputs:
  - start_req outside IDLE.
  - yield_req outside RUN.
  - wr_en outside IDLE (the table cannot be corrupted during a context).
- stored_pc holds its last LOAD value outside LOAD.
- Slot index wraps naturally; no bounds error exists because NUM_PROCS is a power of 2.

Optional Feature:
- Macro QUANTUM_PREEMPT_EN.
- Defined: quantum counter and preempt behave as above.
- Undefined: no counter logic; RUN exits only on yield_req; preempt tied to 0.

Decomposition:
- Package proc_ctx_pkg:
  - State enum (IDLE/LOAD/RUN/SAVE).
  - SLOT_W = log2(NUM_PROCS) helper.
  - Default PC_W.
- One sub-module: proc_quantum_timer.
  - Inputs: clear, enable (RUN & ~hlt).
  - Output: expire.
  - Instantiated only under QUANTUM_PREEMPT_EN.

Test Plan:
- Reset, then wr slot1=0x120, start_req slot1:
  - Next cycle change_proc_pc=1, stored_pc=0x120, proc_num=0.
  - Following cycle proc_num=1.
- In RUN, model only_proc_pc advancing to 0x12A, then yield_req:
  - preempt=0, SAVE cycle.
  - Restart slot1 gives stored_pc=0x12A.
- QUANTUM=8, no hlt, no yield:
  - preempt pulses exactly 8 RUN cycles after LOAD.
  - proc_num=0 the next cycle.
- QUANTUM=8 with hlt high for 3 RUN cycles: preempt delayed to 11 cycles after LOAD.
- yield_req and expiry on the same cycle: one SAVE, preempt=0.
- wr_en and start_req during RUN: ignored, table unchanged.
- Reset during RUN:
  - proc_num=0, IDLE.
  - Table entry for the running slot reads 0x000 on the next LOAD.
  - The reset clears the whole table.
